// File: rtl/vec_mem_sequencer.sv
//==============================================================================
// Module   : vec_mem_sequencer
// Purpose  : Sequences vector loads/stores (LANES elements) and single scalar
//            accesses onto a narrow ELEM_W-wide data RAM. Holds a pipeline
//            stall while a vector access is in flight and gathers load data
//            into a LANES*ELEM_W result vector.
// Optional : define VEC_MEM_STRIDE_EN to add the 'stride' input port (element
//            address step, latched with base_addr). Undefined: step is 1.
// Ports    : clk, rst (async, active-low)
//            vld_req/vst_req/sld_req/sst_req  - access requests (prio in order)
//            base_addr, st_vec, st_scalar, rd_in - request operands
//            stall                            - freeze upstream pipeline
//            mem_addr/mem_wdata/mem_wren/mem_rdata - RAM port
//            ld_vec/ld_rd/ld_valid            - load result to MEM/WB
//            req_err                          - sticky conflicting-request flag
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vec_mem_sequencer #(
    parameter int ADDR_W  = 19,
    parameter int ELEM_W  = 16,
    parameter int LANES   = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld_req,
    input  logic                      vst_req,
    input  logic                      sld_req,
    input  logic                      sst_req,
    input  logic [ADDR_W-1:0]         base_addr,
`ifdef VEC_MEM_STRIDE_EN
    input  logic [ADDR_W-1:0]         stride,
`endif
    input  logic [LANES*ELEM_W-1:0]   st_vec,
    input  logic [ELEM_W-1:0]         st_scalar,
    input  logic [4:0]                rd_in,
    output logic                      stall,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [ELEM_W-1:0]         mem_wdata,
    output logic                      mem_wren,
    input  logic [ELEM_W-1:0]         mem_rdata,
    output logic [LANES*ELEM_W-1:0]   ld_vec,
    output logic [4:0]                ld_rd,
    output logic                      ld_valid,
    output logic                      req_err
);

    localparam int                IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_STORE = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ADDR_W-1:0]          base_q, base_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [LANES*ELEM_W-1:0]    st_vec_q, st_vec_d;
    logic [LANES*ELEM_W-1:0]    gather_q, gather_d;
    logic [LANES*ELEM_W-1:0]    ld_vec_q, ld_vec_d;
    logic [4:0]                 rd_q, rd_d;
    logic [4:0]                 ld_rd_q, ld_rd_d;
    logic                       scalar_q, scalar_d;
    logic                       ld_valid_q, ld_valid_d;
    logic                       req_err_q, req_err_d;

    // Read-issue tracking: one entry per outstanding RAM read, MEM_LAT deep.
    logic                       pipe_vld_q [MEM_LAT];
    logic [IDX_W-1:0]           pipe_idx_q [MEM_LAT];
    logic                       w_issue;
    logic [IDX_W-1:0]           w_issue_idx;
    logic                       w_cap_vld;
    logic [IDX_W-1:0]           w_cap_idx;

    logic                       w_any_req;
    logic                       w_multi_req;
    logic [ADDR_W-1:0]          w_elem_addr;

`ifdef VEC_MEM_STRIDE_EN
    logic [ADDR_W-1:0]          stride_q, stride_d;
    assign w_elem_addr = base_q + ADDR_W'(idx_q) * stride_q;
`else
    assign w_elem_addr = base_q + ADDR_W'(idx_q);
`endif

    assign w_any_req   = vld_req | vst_req | sld_req | sst_req;
    assign w_multi_req = (vld_req & (vst_req | sld_req | sst_req)) |
                         (vst_req & (sld_req | sst_req)) |
                         (sld_req & sst_req);

    assign w_cap_vld = pipe_vld_q[MEM_LAT-1];
    assign w_cap_idx = pipe_idx_q[MEM_LAT-1];

    assign ld_vec   = ld_vec_q;
    assign ld_rd    = ld_rd_q;
    assign ld_valid = ld_valid_q;
    assign req_err  = req_err_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        addr_d     = addr_q;
        st_vec_d   = st_vec_q;
        rd_d       = rd_q;
        scalar_d   = scalar_q;
        ld_vec_d   = ld_vec_q;
        ld_rd_d    = ld_rd_q;
        ld_valid_d = 1'b0;
        req_err_d  = req_err_q;
`ifdef VEC_MEM_STRIDE_EN
        stride_d   = stride_q;
`endif
        stall       = 1'b0;
        mem_addr    = addr_q;
        mem_wdata   = '0;
        mem_wren    = 1'b0;
        w_issue     = 1'b0;
        w_issue_idx = '0;

        // Returning read data always lands in the gather buffer; ld_vec
        // itself only changes when a whole load completes.
        gather_d = gather_q;
        if (w_cap_vld && !scalar_q) begin
            gather_d[int'(w_cap_idx)*ELEM_W +: ELEM_W] = mem_rdata;
        end

        case (state_q)
            S_IDLE: begin
                // The combinational request paths are gated with rst so that
                // all outputs sit at their reset values while rst is low.
                if (rst) begin
                    if (w_multi_req) begin
                        req_err_d = 1'b1;
                    end
                    if (vld_req) begin
                        base_d      = base_addr;
                        rd_d        = rd_in;
                        scalar_d    = 1'b0;
`ifdef VEC_MEM_STRIDE_EN
                        stride_d    = stride;
`endif
                        // Lane 0 is issued straight from the request inputs.
                        mem_addr    = base_addr;
                        addr_d      = base_addr;
                        stall       = 1'b1;
                        w_issue     = 1'b1;
                        w_issue_idx = '0;
                        idx_d       = IDX_W'(1);
                        state_d     = S_LOAD;
                    end else if (vst_req) begin
                        base_d      = base_addr;
                        st_vec_d    = st_vec;
`ifdef VEC_MEM_STRIDE_EN
                        stride_d    = stride;
`endif
                        mem_addr    = base_addr;
                        addr_d      = base_addr;
                        mem_wdata   = st_vec[ELEM_W-1:0];
                        mem_wren    = 1'b1;
                        stall       = 1'b1;
                        idx_d       = IDX_W'(1);
                        state_d     = S_STORE;
                    end else if (sld_req) begin
                        rd_d        = rd_in;
                        scalar_d    = 1'b1;
                        mem_addr    = base_addr;
                        addr_d      = base_addr;
                        w_issue     = 1'b1;
                        w_issue_idx = '0;
                        state_d     = S_DRAIN;
                    end else if (sst_req) begin
                        mem_addr    = base_addr;
                        addr_d      = base_addr;
                        mem_wdata   = st_scalar;
                        mem_wren    = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                stall       = 1'b1;
                mem_addr    = w_elem_addr;
                addr_d      = w_elem_addr;
                w_issue     = 1'b1;
                w_issue_idx = idx_q;
                if (w_any_req) begin
                    req_err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end

            S_DRAIN: begin
                // Stall stays high through the final capture cycle.
                stall = 1'b1;
                if (w_any_req) begin
                    req_err_d = 1'b1;
                end
                if (w_cap_vld && (scalar_q || (w_cap_idx == LAST_IDX))) begin
                    if (scalar_q) begin
                        ld_vec_d                 = '0;
                        ld_vec_d[ELEM_W-1:0]     = mem_rdata;
                    end else begin
                        ld_vec_d                 = gather_d;
                    end
                    ld_rd_d    = rd_q;
                    ld_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            S_STORE: begin
                mem_addr  = w_elem_addr;
                addr_d    = w_elem_addr;
                mem_wdata = st_vec_q[int'(idx_q)*ELEM_W +: ELEM_W];
                mem_wren  = 1'b1;
                // Upstream is released during the last write so the next
                // request can be presented in the following cycle.
                stall     = (idx_q != LAST_IDX);
                if (w_any_req) begin
                    req_err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            st_vec_q   <= '0;
            gather_q   <= '0;
            ld_vec_q   <= '0;
            rd_q       <= '0;
            ld_rd_q    <= '0;
            scalar_q   <= 1'b0;
            ld_valid_q <= 1'b0;
            req_err_q  <= 1'b0;
`ifdef VEC_MEM_STRIDE_EN
            stride_q   <= '0;
`endif
            for (int k = 0; k < MEM_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_idx_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            st_vec_q   <= st_vec_d;
            gather_q   <= gather_d;
            ld_vec_q   <= ld_vec_d;
            rd_q       <= rd_d;
            ld_rd_q    <= ld_rd_d;
            scalar_q   <= scalar_d;
            ld_valid_q <= ld_valid_d;
            req_err_q  <= req_err_d;
`ifdef VEC_MEM_STRIDE_EN
            stride_q   <= stride_d;
`endif
            pipe_vld_q[0] <= w_issue;
            pipe_idx_q[0] <= w_issue_idx;
            for (int k = 1; k < MEM_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_idx_q[k] <= pipe_idx_q[k-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
//==============================================================================
// Module   : tb_vec_mem_sequencer
// Purpose  : Directed self-checking bench for vec_mem_sequencer with a
//            behavioural 1-cycle-latency RAM and a load-result scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vec_mem_sequencer;

    localparam int AW = 19;
    localparam int EW = 16;
    localparam int NL = 16;
    localparam int VW = NL * EW;
`ifdef VEC_MEM_STRIDE_EN
    localparam bit STRIDE_ON = 1'b1;
`else
    localparam bit STRIDE_ON = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            vld_req, vst_req, sld_req, sst_req;
    logic [AW-1:0]   base_addr;
`ifdef VEC_MEM_STRIDE_EN
    logic [AW-1:0]   stride;
`endif
    logic [VW-1:0]   st_vec;
    logic [EW-1:0]   st_scalar;
    logic [4:0]      rd_in;
    logic            stall;
    logic [AW-1:0]   mem_addr;
    logic [EW-1:0]   mem_wdata;
    logic            mem_wren;
    logic [EW-1:0]   mem_rdata;
    logic [VW-1:0]   ld_vec;
    logic [4:0]      ld_rd;
    logic            ld_valid;
    logic            req_err;

    vec_mem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .vld_req   (vld_req),
        .vst_req   (vst_req),
        .sld_req   (sld_req),
        .sst_req   (sst_req),
        .base_addr (base_addr),
`ifdef VEC_MEM_STRIDE_EN
        .stride    (stride),
`endif
        .st_vec    (st_vec),
        .st_scalar (st_scalar),
        .rd_in     (rd_in),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rdata (mem_rdata),
        .ld_vec    (ld_vec),
        .ld_rd     (ld_rd),
        .ld_valid  (ld_valid),
        .req_err   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, one-cycle registered read.
    logic [EW-1:0] ram [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [EW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)        ram[pre_addr] <= pre_data;
        else if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int tests = 0;
    int fails = 0;
    int lv_total = 0;

    typedef struct packed {
        logic [VW-1:0] vec;
        logic [4:0]    rd;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ld_valid pulse must match the oldest expected load.
    always @(negedge clk) begin
        if (ld_valid) begin
            lv_total++;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL ld_unexpected: observed ld_valid=1 expected no load pending");
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("ld_vec", ld_vec, mon_e.vec);
                chk("ld_rd", {251'd0, ld_rd}, {251'd0, mon_e.rd});
            end
        end
    end

    // Vector load with optional same-cycle vst conflict and a late vst during LOAD.
    task automatic vload(input logic [AW-1:0] base, input logic [4:0] rd, input int strd,
                         input bit also_vst, input int late_at, input string tag);
        exp_t          e;
        logic [AW-1:0] a;
        int            eff;
        int            st_n;
        int            wr_n;
        int            lv_at;
        eff   = STRIDE_ON ? strd : 1;
        st_n  = 0;
        wr_n  = 0;
        lv_at = -1;
        e     = '0;
        for (int i = 0; i < NL; i++) begin
            a = base + AW'(i * eff);
            e.vec[i*EW +: EW] = ram[a];
        end
        e.rd = rd;
        sb.push_back(e);
`ifdef VEC_MEM_STRIDE_EN
        stride = AW'(strd);
`endif
        vld_req   = 1'b1;
        vst_req   = also_vst;
        base_addr = base;
        rd_in     = rd;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < NL) chk({tag, "_addr"}, mem_addr, base + AW'(c * eff));
            st_n += int'(stall);
            wr_n += int'(mem_wren);
            if (ld_valid && lv_at < 0) lv_at = c;
            @(posedge clk);
            #1;
            vld_req = 1'b0;
            vst_req = (c + 1 == late_at);
        end
        chk({tag, "_stall_cycles"}, st_n, 17);
        chk({tag, "_ld_valid_cycle"}, lv_at, 17);
        chk({tag, "_no_writes"}, wr_n, 0);
    endtask

    initial begin
        logic [VW-1:0] obs;
        logic [AW-1:0] a;
        int            wr_n;
        int            st_n;
        int            lv_at;
        int            lv_saved;

        rst = 1'b0;
        vld_req = 1'b0; vst_req = 1'b0; sld_req = 1'b0; sst_req = 1'b0;
        base_addr = '0; st_vec = '0; st_scalar = '0; rd_in = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef VEC_MEM_STRIDE_EN
        stride = AW'(1);
`endif

        // Preload RAM[0x100+i] = i*3 while in reset.
        for (int i = 0; i < NL; i++) begin
            @(posedge clk); #1;
            pre_we = 1'b1; pre_addr = AW'(32'h100 + i); pre_data = EW'(i * 3);
        end
        @(posedge clk); #1;
        pre_we = 1'b0;

        // Reset state, with a request held to show it is ignored in reset.
        vld_req = 1'b1; base_addr = AW'(32'h55);
        @(negedge clk);
        chk("rst_stall",     stall,     0);
        chk("rst_mem_wren",  mem_wren,  0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ld_vec",    ld_vec,    0);
        chk("rst_ld_rd",     ld_rd,     0);
        chk("rst_ld_valid",  ld_valid,  0);
        chk("rst_req_err",   req_err,   0);
        @(posedge clk); #1;
        vld_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic vector load.
        vload(AW'(32'h100), 5'd7, 1, 1'b0, -1, "vld1");
        chk("vld1_req_err", req_err, 0);

        // Vector store wrapping the top of the address space.
        for (int i = 0; i < NL; i++) st_vec[i*EW +: EW] = EW'(32'hA000 + i);
        base_addr = AW'(32'h7FFF8);
        vst_req = 1'b1;
        wr_n = 0; st_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            wr_n += int'(mem_wren);
            st_n += int'(stall);
            @(posedge clk); #1;
            vst_req = 1'b0;
        end
        chk("vst_wren_cycles",  wr_n, 16);
        chk("vst_stall_cycles", st_n, 15);
        obs = '0;
        for (int i = 0; i < NL; i++) begin
            a = AW'(32'h7FFF8) + AW'(i);
            obs[i*EW +: EW] = ram[a];
        end
        chk("vst_ram_data", obs, st_vec);
        chk("vst_req_err", req_err, 0);

        // Conflict: vld+vst together, then a vst during LOAD.
        vload(AW'(32'h100), 5'd3, 1, 1'b1, 5, "conf");
        chk("conf_req_err", req_err, 1);

        // Reset in the cycle lane 5 is issued.
        vld_req = 1'b1; base_addr = AW'(32'h100); rd_in = 5'd9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vld_req = 1'b0;
        end
        lv_saved = lv_total;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall",    stall,    0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_wren", mem_wren, 0);
        chk("mid_rst_ld_vec",   ld_vec,   0);
        chk("mid_rst_ld_rd",    ld_rd,    0);
        chk("mid_rst_req_err",  req_err,  0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_ld_valid", lv_total, lv_saved);
        vload(AW'(32'h100), 5'd9, 1, 1'b0, -1, "after_rst");
        chk("after_rst_req_err", req_err, 0);

        // Scalar store then scalar load of the same address.
        base_addr = AW'(32'h20); st_scalar = 16'hBEEF; sst_req = 1'b1;
        @(negedge clk);
        chk("sst_wren",  mem_wren,  1);
        chk("sst_addr",  mem_addr,  32'h20);
        chk("sst_wdata", mem_wdata, 32'hBEEF);
        chk("sst_stall", stall,     0);
        @(posedge clk); #1;
        sst_req = 1'b0; sld_req = 1'b1; rd_in = 5'd4;
        sb.push_back('{vec: VW'(32'hBEEF), rd: 5'd4});
        lv_at = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) chk("sld_capture_stall", stall, 1);
            if (ld_valid && lv_at < 0) lv_at = c;
            @(posedge clk); #1;
            sld_req = 1'b0;
        end
        chk("sld_ld_valid_cycle", lv_at, 2);
        @(negedge clk);
        chk("idle_addr_hold", mem_addr, 32'h20);
        chk("idle_wren", mem_wren, 0);
        @(posedge clk); #1;

        // Strided (or unit-stride) load from base 0, with a late request.
        vload(AW'(0), 5'd1, 4, 1'b0, 3, "stride");
        chk("stride_req_err", req_err, 1);

        chk("ld_valid_total", lv_total, 5);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Vector memory sequencer between the EX/MEM pipeline register and the 16-bit-wide data RAM. It turns one vector load into 16 element reads gathered into a 256-bit vector, and one vector store into 16 element writes. It also handles single scalar accesses. While a vector access is in flight it holds a stall to freeze the upstream pipeline. It replaces ad-hoc per-element address, input and output management with one state machine.

## Interface
Parameters:
- ADDR_W, 19, RAM address / scalar width
- ELEM_W, 16, element and RAM data width
- LANES, 16, elements per vector
- MEM_LAT, 1, RAM read latency in cycles (1..3)

Ports:
- clk  in  1  pipeline clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- vld_req  in  1  vector load request (1-cycle pulse from EX/MEM)
- vst_req  in  1  vector store request
- sld_req  in  1  scalar load request
- sst_req  in  1  scalar store request
- base_addr  in  ADDR_W  element-0 address
- st_vec  in  LANES*ELEM_W  store data, lane i at bits [i*ELEM_W +: ELEM_W]
- st_scalar  in  ELEM_W  scalar store data
- rd_in  in  5  destination register of the load
- stall  out  1  freeze pipeline stages IF..EX/MEM
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  ELEM_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_rdata  in  ELEM_W  RAM read data
- ld_vec  out  LANES*ELEM_W  gathered load result; scalar load zero-extended into lane 0
- ld_rd  out  5  destination register for ld_vec
- ld_valid  out  1  1-cycle pulse: ld_vec and ld_rd are valid for MEM/WB
- req_err  out  1  sticky flag: conflicting or overlapped request seen

## Operation
- States: IDLE, LOAD, DRAIN, STORE.
- Request priority in IDLE: vld > vst > sld > sst.
- More than one request high in the same cycle: the highest-priority request executes and req_err is set.
- IDLE + vld_req:
  - latch base_addr and rd_in; set idx=0; go to LOAD.
  - stall is asserted combinationally in the same cycle.
- LOAD:
  - mem_addr = base + idx*STRIDE; idx increments each cycle.
  - After idx = LANES-1 is issued, go to DRAIN.
- Read capture: a MEM_LAT-deep shift of issued lane indices captures mem_rdata into lane cap_idx of ld_vec.
- DRAIN:
  - wait until lane LANES-1 is captured.
  - Then pulse ld_valid, deassert stall, go to IDLE.
- IDLE + vst_req:
  - latch base_addr and st_vec; go to STORE.
  - mem_wren=1 and mem_wdata = lane idx each cycle.
  - After lane LANES-1 is written, go to IDLE; stall drops that cycle.
- Scalar load:
  - one issue cycle, then MEM_LAT capture cycles.
  - ld_vec = {zeros, mem_rdata}, ld_valid pulse; stall held during the capture cycles.
- Scalar store:
  - handled combinationally in IDLE: mem_addr=base_addr, mem_wdata=st_scalar, mem_wren=1.
  - no stall.
- Address arithmetic is modulo 2^ADDR_W; addresses wrap from 2^ADDR_W-1 to 0 with no error.
- Requests arriving while not in IDLE are ignored and set req_err. Upstream must not issue them while stall=1.
- req_err clears only on reset.
- Outside active access: mem_wren=0, and mem_addr holds its last value.

## Timing
- Reset values (asynchronous, rst=0): state=IDLE, stall=0, mem_wren=0, mem_addr=0, mem_wdata=0, ld_vec=0, ld_rd=0, ld_valid=0, req_err=0, idx=0.
- Reset mid-operation: the access is aborted immediately. Lanes already written stay in RAM; no ld_valid is produced.
- Vector load, request sampled at edge T0:
  - addresses driven in cycles T0..T0+LANES-1;
  - ld_valid high in cycle T0+LANES-1+MEM_LAT+1;
  - stall high T0..T0+LANES+MEM_LAT-1. Default: 17 stall cycles, ld_valid in cycle 17.
- Vector store: writes in cycles T0..T0+LANES-1; stall high T0..T0+LANES-2, i.e. 15 cycles.
- Scalar load: ld_valid in cycle T0+MEM_LAT+1 after issue.
- ld_vec holds its value until the next load completes.
- Back-to-back: a new request is accepted in the cycle after ld_valid (load) or after the last write (store).

## Configuration
- VEC_MEM_STRIDE_EN defined:
  - adds input port stride (ADDR_W); STRIDE is latched with base_addr.
  - stride 0 is legal and repeats the same address.
- Not defined: the stride port is absent and STRIDE is the constant 1.

## Test plan
- Vector load: RAM[0x100+i]=i*3, vld_req, base=0x100, rd_in=7 -> ld_valid exactly 17 cycles later; lane i = i*3, ld_rd=7, stall high 17 cycles.
- Vector store: st_vec lane i = 0xA000+i, base=0x7FFF8 -> RAM[0x7FFF8..0x7FFFF] and RAM[0..7] written (wrap), mem_wren high exactly 16 cycles.
- Conflict: vld_req and vst_req in the same cycle -> load executes, no writes, req_err=1; vst_req during LOAD -> ignored, req_err stays 1.
- Reset mid-load: rst low at lane 5 -> all outputs at reset values in the same cycle; no ld_valid; the next vld_req completes normally.
- Scalar ops: sst_req addr=0x20 data=0xBEEF, then sld_req addr=0x20 -> ld_vec=0x...0000BEEF, ld_valid at T0+2, no stall on the store.
- With VEC_MEM_STRIDE_EN, stride=4, base=0 -> addresses 0,4,...,60 issued; without the macro, addresses 0..15.
